mem_responder: RTL

//  Memory-side responder for the CPU's 8-bit, 20-bit-address bus: pin_a, pin_o, pin_w, pin_i, pin_ce.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// CPU-side and SRAM-side signal bundle for mem_responder.
// The slave modport is the responder's view; master is the CPU/SRAM environment's view.
interface mem_responder_if;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;

  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_o;
  logic          cpu_w;
  logic [DW-1:0] cpu_i;
  logic          cpu_ce;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic          sram_we;
  logic          sram_req;
  logic [DW-1:0] sram_q;
  logic          sram_ack;
  logic          bus_err;

  modport slave (
    input  cpu_a, cpu_o, cpu_w, sram_q, sram_ack,
    output cpu_i, cpu_ce, sram_a, sram_d, sram_we, sram_req, bus_err
  );

  modport master (
    output cpu_a, cpu_o, cpu_w, sram_q, sram_ack,
    input  cpu_i, cpu_ce, sram_a, sram_d, sram_we, sram_req, bus_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU accesses from SRAM over req/ack with a one-entry write-through cache.
// Optional MEMRESP_ROM_PROTECT_EN: IDLE writes at or above ROM_BASE complete without touching SRAM.
module mem_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [19:0] ROM_BASE    = 20'hF0000
) (
  input logic            pin_clock,
  input logic            pin_reset,
  mem_responder_if.slave bus
);
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 8;
  localparam int unsigned WW = 4;

`ifdef MEMRESP_ROM_PROTECT_EN
  localparam bit ROM_PROT = 1'b1;
`else
  localparam bit ROM_PROT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] sram_a, sram_a_nxt;
  logic [DW-1:0] sram_d, sram_d_nxt;
  logic          sram_we, sram_we_nxt;
  logic          sram_req, sram_req_nxt;
  logic [DW-1:0] cpu_i, cpu_i_nxt;
  logic          bus_err, bus_err_nxt;
  logic          valid, valid_nxt;
  logic [AW-1:0] tag_a, tag_a_nxt;
  logic [DW-1:0] tag_d, tag_d_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic [DW-1:0] fill_c;
  logic          hit_c, rom_wr_c, cpu_ce_c;

  // Writes never hit so every write is carried through to SRAM.
  assign hit_c    = valid & (bus.cpu_a == tag_a) & ~bus.cpu_w;
  assign rom_wr_c = ROM_PROT & bus.cpu_w & (bus.cpu_a >= ROM_BASE);
  assign fill_c   = sram_we ? sram_d : bus.sram_q;

  always_ff @(posedge pin_clock or posedge pin_reset) begin
    if (pin_reset) begin
      state    <= IDLE;
      sram_a   <= '0;
      sram_d   <= '0;
      sram_we  <= 1'b0;
      sram_req <= 1'b0;
      cpu_i    <= 8'hFF;
      bus_err  <= 1'b0;
      valid    <= 1'b0;
      tag_a    <= '0;
      tag_d    <= '0;
      tmo_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sram_a   <= sram_a_nxt;
      sram_d   <= sram_d_nxt;
      sram_we  <= sram_we_nxt;
      sram_req <= sram_req_nxt;
      cpu_i    <= cpu_i_nxt;
      bus_err  <= bus_err_nxt;
      valid    <= valid_nxt;
      tag_a    <= tag_a_nxt;
      tag_d    <= tag_d_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and next-output logic; bus_err is a one-cycle pulse by default.
  always_comb begin
    state_nxt    = state;
    sram_a_nxt   = sram_a;
    sram_d_nxt   = sram_d;
    sram_we_nxt  = sram_we;
    sram_req_nxt = sram_req;
    cpu_i_nxt    = cpu_i;
    bus_err_nxt  = 1'b0;
    valid_nxt    = valid;
    tag_a_nxt    = tag_a;
    tag_d_nxt    = tag_d;
    tmo_cnt_nxt  = tmo_cnt;
    wait_cnt_nxt = wait_cnt;
    cpu_ce_c     = 1'b0;
    case (state)
      IDLE: begin
        if (hit_c) begin
          cpu_ce_c  = 1'b1;
          cpu_i_nxt = tag_d;
        end else if (rom_wr_c) begin
          state_nxt = DONE;
        end else begin
          sram_a_nxt   = bus.cpu_a;
          sram_d_nxt   = bus.cpu_o;
          sram_we_nxt  = bus.cpu_w;
          sram_req_nxt = 1'b1;
          tmo_cnt_nxt  = '0;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still completes the access normally.
        if (bus.sram_ack) begin
          sram_req_nxt = 1'b0;
          valid_nxt    = 1'b1;
          tag_a_nxt    = sram_a;
          tag_d_nxt    = fill_c;
          cpu_i_nxt    = fill_c;
          wait_cnt_nxt = '0;
          state_nxt    = (WAIT_STATES == 0) ? DONE : WAIT;
        end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
          sram_req_nxt = 1'b0;
          valid_nxt    = 1'b0;
          cpu_i_nxt    = 8'hFF;
          bus_err_nxt  = 1'b1;
          state_nxt    = DONE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      WAIT: begin
        if (wait_cnt == WW'(WAIT_STATES - 1)) begin
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      DONE: begin
        cpu_ce_c  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cpu_i    = cpu_i;
  assign bus.cpu_ce   = cpu_ce_c;
  assign bus.sram_a   = sram_a;
  assign bus.sram_d   = sram_d;
  assign bus.sram_we  = sram_we;
  assign bus.sram_req = sram_req;
  assign bus.bus_err  = bus_err;
endmodule
